// File: rtl/mano_control_unit.sv
// Hardwired timing/control unit for the Mano basic computer: sequence counter, run flag, strobe decode.
// Define MANO_IO_EN to add the FGI/FGO interrupt-free I/O instructions (INP, OUT, SKI, SKO).
module mano_control_unit #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] ir,
  input  logic              dr_zero,
  input  logic              ac_zero,
  input  logic              ac_sign,
  input  logic              e_flag,
`ifdef MANO_IO_EN
  input  logic              fgi,
  input  logic              fgo,
  output logic              outr_ld,
  output logic              fgi_clr,
  output logic              fgo_clr,
`endif
  output logic              ar_ld,
  output logic              ar_inc,
  output logic              ar_clr,
  output logic              pc_ld,
  output logic              pc_inc,
  output logic              pc_clr,
  output logic              dr_ld,
  output logic              dr_inc,
  output logic              dr_clr,
  output logic              ac_ld,
  output logic              ac_inc,
  output logic              ac_clr,
  output logic              ir_ld,
  output logic              tr_ld,
  output logic              e_clr,
  output logic              e_cmp,
  output logic [2:0]        bus_sel,
  output logic [2:0]        alu_op,
  output logic              mem_read,
  output logic              mem_write,
  output logic              run,
  output logic [6:0]        t_state
);

  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, T5 = 3'd5, T6 = 3'd6
  } sc_t;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0, BUS_AR = 3'd1, BUS_PC = 3'd2, BUS_DR = 3'd3,
    BUS_AC = 3'd4, BUS_IR = 3'd5, BUS_TR = 3'd6, BUS_MEM = 3'd7
  } bus_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0, ALU_ADD = 3'd1, ALU_DR = 3'd2, ALU_CMA = 3'd3,
    ALU_CIR = 3'd4, ALU_CIL = 3'd5, ALU_INPR = 3'd6
  } alu_t;

  sc_t  sc, sc_next;
  logic run_next;
  bus_t bus;
  alu_t alu;

  logic              ind;
  logic [2:0]        opc;
  logic [ADDR_W-1:0] rb;

  assign ind = ir[WORD_W-1];
  assign opc = ir[WORD_W-2:ADDR_W];
  assign rb  = ir[ADDR_W-1:0];

  assign bus_sel = bus;
  assign alu_op  = alu;
  assign t_state = 7'd1 << sc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sc  <= T0;
      run <= 1'b0;
    end else begin
      sc  <= sc_next;
      run <= run_next;
    end
  end

  always_comb begin
    ar_ld = 1'b0; ar_inc = 1'b0; ar_clr = 1'b0;
    pc_ld = 1'b0; pc_inc = 1'b0; pc_clr = 1'b0;
    dr_ld = 1'b0; dr_inc = 1'b0; dr_clr = 1'b0;
    ac_ld = 1'b0; ac_inc = 1'b0; ac_clr = 1'b0;
    ir_ld = 1'b0; tr_ld = 1'b0; e_clr = 1'b0; e_cmp = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    bus = BUS_NONE;
    alu = ALU_AND;
`ifdef MANO_IO_EN
    outr_ld = 1'b0; fgi_clr = 1'b0; fgo_clr = 1'b0;
`endif
    sc_next  = T0;
    run_next = run;

    if (!run) begin
      run_next = start;
    end else begin
      case (sc)
        T0: begin
          bus = BUS_PC; ar_ld = 1'b1; sc_next = T1;
        end
        T1: begin
          mem_read = 1'b1; bus = BUS_MEM; ir_ld = 1'b1; pc_inc = 1'b1; sc_next = T2;
        end
        T2: begin
          bus = BUS_IR; ar_ld = 1'b1; sc_next = T3;
        end
        T3: begin
          if (opc != 3'd7) begin
            sc_next = T4;
            if (ind) begin
              mem_read = 1'b1; bus = BUS_MEM; ar_ld = 1'b1;
            end
          end else if (!ind) begin
            // AC load sources outrank clear/increment; CMA > CIR > CIL among them
            if (rb[9]) begin
              ac_ld = 1'b1; alu = ALU_CMA;
            end else if (rb[7]) begin
              ac_ld = 1'b1; alu = ALU_CIR;
            end else if (rb[6]) begin
              ac_ld = 1'b1; alu = ALU_CIL;
            end else begin
              ac_clr = rb[11];
              ac_inc = rb[5];
            end
            e_clr  = rb[10];
            e_cmp  = rb[8];
            pc_inc = (rb[4] & ~ac_sign) | (rb[3] & ac_sign) |
                     (rb[2] & ac_zero)  | (rb[1] & ~e_flag);
            if (rb[0]) run_next = 1'b0;
          end else begin
`ifdef MANO_IO_EN
            if (rb[11]) begin
              ac_ld = 1'b1; alu = ALU_INPR; fgi_clr = 1'b1;
            end
            if (rb[10]) begin
              bus = BUS_AC; outr_ld = 1'b1; fgo_clr = 1'b1;
            end
            pc_inc = (rb[9] & fgi) | (rb[8] & fgo);
`endif
          end
        end
        T4: begin
          case (opc)
            3'd0, 3'd1, 3'd2: begin
              mem_read = 1'b1; bus = BUS_MEM; dr_ld = 1'b1; sc_next = T5;
            end
            3'd3: begin
              bus = BUS_AC; mem_write = 1'b1;
            end
            3'd4: begin
              bus = BUS_AR; pc_ld = 1'b1;
            end
            3'd5: begin
              bus = BUS_PC; mem_write = 1'b1; ar_inc = 1'b1; sc_next = T5;
            end
            3'd6: begin
              mem_read = 1'b1; bus = BUS_MEM; dr_ld = 1'b1; sc_next = T5;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opc)
            3'd0, 3'd1, 3'd2: begin
              ac_ld = 1'b1; alu = alu_t'(opc);
            end
            3'd5: begin
              bus = BUS_AR; pc_ld = 1'b1;
            end
            3'd6: begin
              dr_inc = 1'b1; sc_next = T6;
            end
            default: ;
          endcase
        end
        T6: begin
          if (opc == 3'd6) begin
            bus = BUS_DR; mem_write = 1'b1; pc_inc = dr_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mano_control_unit.sv
// Scoreboard bench for mano_control_unit: an instruction-level model queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mano_control_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] ir;
  logic        dr_zero, ac_zero, ac_sign, e_flag;
  logic        ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr;
  logic        dr_ld, dr_inc, dr_clr, ac_ld, ac_inc, ac_clr;
  logic        ir_ld, tr_ld, e_clr, e_cmp, mem_read, mem_write, run;
  logic [2:0]  bus_sel, alu_op;
  logic [6:0]  t_state;
`ifdef MANO_IO_EN
  logic        fgi, fgo, outr_ld, fgi_clr, fgo_clr;
  assign fgi = 1'b0;
  assign fgo = 1'b0;
`endif

  mano_control_unit #(.ADDR_W(12), .WORD_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ir(ir),
    .dr_zero(dr_zero), .ac_zero(ac_zero), .ac_sign(ac_sign), .e_flag(e_flag),
`ifdef MANO_IO_EN
    .fgi(fgi), .fgo(fgo), .outr_ld(outr_ld), .fgi_clr(fgi_clr), .fgo_clr(fgo_clr),
`endif
    .ar_ld(ar_ld), .ar_inc(ar_inc), .ar_clr(ar_clr),
    .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_clr(pc_clr),
    .dr_ld(dr_ld), .dr_inc(dr_inc), .dr_clr(dr_clr),
    .ac_ld(ac_ld), .ac_inc(ac_inc), .ac_clr(ac_clr),
    .ir_ld(ir_ld), .tr_ld(tr_ld), .e_clr(e_clr), .e_cmp(e_cmp),
    .bus_sel(bus_sel), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write),
    .run(run), .t_state(t_state)
  );

  typedef struct packed {
    logic ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr;
    logic dr_ld, dr_inc, dr_clr, ac_ld, ac_inc, ac_clr;
    logic ir_ld, tr_ld, e_clr, e_cmp;
    logic [2:0] bus_sel;
    logic [2:0] alu_op;
    logic mem_read, mem_write, run;
    logic [6:0] t_state;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  o;
  } exp_rec_t;

  exp_rec_t exp_q[$];
  exp_rec_t stage_q[$];
  exp_rec_t cur;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish (checks=%0d)", n_checks);
    $fatal(1, "timeout");
  end

  function automatic obs_t sample();
    obs_t o;
    o.ar_ld = ar_ld; o.ar_inc = ar_inc; o.ar_clr = ar_clr;
    o.pc_ld = pc_ld; o.pc_inc = pc_inc; o.pc_clr = pc_clr;
    o.dr_ld = dr_ld; o.dr_inc = dr_inc; o.dr_clr = dr_clr;
    o.ac_ld = ac_ld; o.ac_inc = ac_inc; o.ac_clr = ac_clr;
    o.ir_ld = ir_ld; o.tr_ld = tr_ld; o.e_clr = e_clr; o.e_cmp = e_cmp;
    o.bus_sel = bus_sel; o.alu_op = alu_op;
    o.mem_read = mem_read; o.mem_write = mem_write;
    o.run = run; o.t_state = t_state;
    return o;
  endfunction

  function automatic obs_t idle_obs(input logic r, input int unsigned t);
    obs_t o;
    o = '0;
    o.run = r;
    o.t_state = 7'(1 << t);
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      check(cur.tag, sample(), cur.o);
    end
  end

  task automatic stage(input obs_t o, input logic [15:0] w, input int unsigned t);
    exp_rec_t e;
    e.tag = $sformatf("ir=%h T%0d", w, t);
    e.o = o;
    stage_q.push_back(e);
  endtask

  // Instruction-level reference: expected cycle-by-cycle strobes for one instruction.
  task automatic model_instr(input logic [15:0] w, input logic [3:0] f,
                             output int unsigned n, output logic halts);
    logic dz, az, asg, ef, ind;
    int unsigned d;
    logic [11:0] r;
    obs_t o;
    int unsigned lb[3];
    logic [2:0] lop[3];
    logic found;
    int unsigned skips;
    {dz, az, asg, ef} = f;
    ind = w[15];
    d = w[14:12];
    r = w[11:0];
    lb = '{9, 7, 6};
    lop = '{3'd3, 3'd4, 3'd5};
    stage_q.delete();
    halts = 1'b0;

    o = idle_obs(1, 0); o.bus_sel = 3'd2; o.ar_ld = 1; stage(o, w, 0);
    o = idle_obs(1, 1); o.mem_read = 1; o.bus_sel = 3'd7; o.ir_ld = 1; o.pc_inc = 1; stage(o, w, 1);
    o = idle_obs(1, 2); o.bus_sel = 3'd5; o.ar_ld = 1; stage(o, w, 2);
    o = idle_obs(1, 3);
    if (d == 7) begin
      if (!ind) begin
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
          if (!found && r[lb[k]]) begin
            found = 1'b1; o.ac_ld = 1; o.alu_op = lop[k];
          end
        end
        if (!found) begin
          o.ac_clr = r[11];
          o.ac_inc = r[5];
        end
        o.e_clr = r[10];
        o.e_cmp = r[8];
        skips = 0;
        if (r[4] && !asg) skips++;
        if (r[3] && asg)  skips++;
        if (r[2] && az)   skips++;
        if (r[1] && !ef)  skips++;
        o.pc_inc = (skips > 0);
        halts = r[0];
      end
      stage(o, w, 3);
      n = 4;
    end else begin
      if (ind) begin o.mem_read = 1; o.bus_sel = 3'd7; o.ar_ld = 1; end
      stage(o, w, 3);
      case (d)
        0, 1, 2: begin
          o = idle_obs(1, 4); o.mem_read = 1; o.bus_sel = 3'd7; o.dr_ld = 1; stage(o, w, 4);
          o = idle_obs(1, 5); o.ac_ld = 1; o.alu_op = 3'(d); stage(o, w, 5);
          n = 6;
        end
        3: begin
          o = idle_obs(1, 4); o.bus_sel = 3'd4; o.mem_write = 1; stage(o, w, 4);
          n = 5;
        end
        4: begin
          o = idle_obs(1, 4); o.bus_sel = 3'd1; o.pc_ld = 1; stage(o, w, 4);
          n = 5;
        end
        5: begin
          o = idle_obs(1, 4); o.bus_sel = 3'd2; o.mem_write = 1; o.ar_inc = 1; stage(o, w, 4);
          o = idle_obs(1, 5); o.bus_sel = 3'd1; o.pc_ld = 1; stage(o, w, 5);
          n = 6;
        end
        default: begin
          o = idle_obs(1, 4); o.mem_read = 1; o.bus_sel = 3'd7; o.dr_ld = 1; stage(o, w, 4);
          o = idle_obs(1, 5); o.dr_inc = 1; stage(o, w, 5);
          o = idle_obs(1, 6); o.bus_sel = 3'd3; o.mem_write = 1; o.pc_inc = dz; stage(o, w, 6);
          n = 7;
        end
      endcase
    end
  endtask

  task automatic push_idle(input string tag, input int unsigned cnt);
    exp_rec_t e;
    for (int unsigned k = 0; k < cnt; k++) begin
      e.tag = tag;
      e.o = idle_obs(0, 0);
      exp_q.push_back(e);
    end
  endtask

  // Called #1 after a rising edge while halted; returns #1 after the edge that sets run.
  task automatic do_start();
    start = 1'b1;
    push_idle("start_cycle", 1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_instr(input logic [15:0] w, input logic [3:0] f, input logic st);
    int unsigned n;
    logic halts;
    ir = w;
    {dr_zero, ac_zero, ac_sign, e_flag} = f;
    start = st;
    model_instr(w, f, n, halts);
    while (stage_q.size() != 0) exp_q.push_back(stage_q.pop_front());
    repeat (n) @(posedge clk);
    #1;
    start = 1'b0;
    if (halts) begin
      push_idle("halted", 10);
      repeat (10) @(posedge clk);
      #1;
      do_start();
    end
  endtask

  initial begin
    logic [15:0] w;
    int unsigned n;
    logic halts;
    reset_n = 1'b0;
    start = 1'b0;
    ir = '0;
    {dr_zero, ac_zero, ac_sign, e_flag} = 4'b0000;
    push_idle("reset", 2);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    do_start();

    run_instr(16'h2005, 4'b0000, 1'b0);
    run_instr(16'h9010, 4'b0000, 1'b0);
    run_instr(16'h6020, 4'b1000, 1'b0);
    run_instr(16'h6020, 4'b0000, 1'b0);
    run_instr(16'h7004, 4'b0100, 1'b0);
    run_instr(16'h7004, 4'b0000, 1'b0);
    run_instr(16'h7001, 4'b0000, 1'b0);
    run_instr(16'h7280, 4'b0000, 1'b1);
    run_instr(16'h7820, 4'b0000, 1'b0);

    for (int i = 0; i < 60; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 1) == 1) w[15:12] = 4'h7;
`ifdef MANO_IO_EN
      if (w[15:12] == 4'hF) w[15] = 1'b0;
`endif
      run_instr(w, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of BSA T4.
    ir = 16'h5123;
    model_instr(ir, 4'b0000, n, halts);
    for (int k = 0; k < 5; k++) exp_q.push_back(stage_q[k]);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check("reset_async", sample(), idle_obs(0, 0));
    push_idle("reset_hold", 3);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    do_start();
    run_instr(16'h3044, 4'b0000, 1'b0);
    run_instr(16'h4010, 4'b0000, 1'b0);

    @(posedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mano_control_unit.md
Name: mano_control_unit

Overview:
- Hardwired timing and control unit for the Mano basic computer datapath.
- Runs a 3-bit sequence counter (T0..T6) and decodes the IR contents.
- Drives the ld/inc/clr strobes of the datapath registers (AR, PC, DR, AC, IR, TR), plus the common-bus select, memory read/write and ALU op.
- It is the controlling end of the register ld/inc/clr interface; the registers only obey these strobes.

Parameters:
- ADDR_W, 12, address field width: AR and IR[11:0].
- WORD_W, 16, instruction and data word width.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; sets run when halted.
- ir  in  WORD_W  current IR register output.
- dr_zero  in  1  DR==0, as seen by the datapath.
- ac_zero  in  1  AC==0.
- ac_sign  in  1  AC[15].
- e_flag  in  1  E flip-flop value.
- ar_ld, ar_inc, ar_clr  out  1 each  AR strobes.
- pc_ld, pc_inc, pc_clr  out  1 each  PC strobes.
- dr_ld, dr_inc, dr_clr  out  1 each  DR strobes.
- ac_ld, ac_inc, ac_clr  out  1 each  AC strobes.
- ir_ld  out  1  IR load.
- tr_ld  out  1  TR load (reserved, never asserted).
- e_clr, e_cmp  out  1 each  E clear / complement.
- bus_sel  out  3  bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM.
- alu_op  out  3  0 AND, 1 ADD, 2 DR, 3 CMA, 4 CIR, 5 CIL, 6 INPR.
- mem_read, mem_write  out  1 each  memory strobes.
- run  out  1  S flip-flop; high while executing.
- t_state  out  7  one-hot T0..T6.

Behaviour:
- Reset (async, reset_n=0): sc=0, run=0.
  - Outputs then: all strobes 0, bus_sel=0, alu_op=0, t_state=7'b0000001.
  - Takes effect mid-instruction; the partial instruction is abandoned.
- Registered state: sc[2:0] and run only. All strobes are combinational from (sc, run, ir, flags).
  - Strobes are valid during a Tn cycle; the datapath acts on the clock edge that ends that cycle.
- Halted (run=0): every strobe is 0 and sc holds 0. On a start pulse, run goes to 1 at the next edge.
- Sequencing: sc increments each cycle while run=1. "SC<-0" means sc=0 next cycle. sc never exceeds 6.
- Fetch:
  - T0: bus_sel=2, ar_ld.
  - T1: mem_read, bus_sel=7, ir_ld, pc_inc.
- Decode, T2: bus_sel=5, ar_ld. From here I=ir[15], D=ir[14:12], decoded from the held ir input.
- T3 branches:
  - D!=7 & I=1: mem_read, bus_sel=7, ar_ld (indirect).
  - D!=7 & I=0: no strobes.
  - D=7 & I=0: register reference (below), then SC<-0.
  - D=7 & I=1: I/O (see Optional Feature), then SC<-0.
- Memory reference, T4 onward:
  - AND / ADD / LDA (D=0/1/2): T4 mem_read, bus_sel=7, dr_ld. T5 ac_ld with alu_op=0/1/2, SC<-0.
  - STA (D=3): T4 bus_sel=4, mem_write, SC<-0.
  - BUN (D=4): T4 bus_sel=1, pc_ld, SC<-0.
  - BSA (D=5): T4 bus_sel=2, mem_write, ar_inc. T5 bus_sel=1, pc_ld, SC<-0.
  - ISZ (D=6): T4 mem_read, bus_sel=7, dr_ld. T5 dr_inc. T6 bus_sel=3, mem_write, pc_inc if dr_zero, SC<-0.
  - ISZ dr_zero is sampled in T6, after the increment.
- Register reference, T3 only. Each set bit of ir[11:0] is acted on; multiple bits may be set together.
  - Bit 11 CLA: ac_clr.
  - Bit 10 CLE: e_clr.
  - Bit 9 CMA: ac_ld, alu_op=3.
  - Bit 8 CME: e_cmp.
  - Bit 7 CIR: ac_ld, alu_op=4.
  - Bit 6 CIL: ac_ld, alu_op=5.
  - Bit 5 INC: ac_inc.
  - Bit 4 SPA: pc_inc if !ac_sign.
  - Bit 3 SNA: pc_inc if ac_sign.
  - Bit 2 SZA: pc_inc if ac_zero.
  - Bit 1 SZE: pc_inc if !e_flag.
  - Bit 0 HLT: run=0 next edge.
- Register-reference conflicts:
  - Any ac_ld source wins over ac_clr and ac_inc. Among the ac_ld sources, priority is CMA > CIR > CIL.
  - Skip conditions are ORed into a single pc_inc.
- Only one bus source is driven per cycle. mem_read and mem_write are never both high.
- start while run=1 is ignored.

Optional Feature:
- Macro MANO_IO_EN.
- Defined:
  - Extra inputs fgi, fgo. Extra outputs outr_ld, fgi_clr, fgo_clr.
  - At T3 with D=7, I=1: INP (ir[11]) gives ac_ld, alu_op=6, fgi_clr. OUT (ir[10]) gives bus_sel=4, outr_ld, fgo_clr. SKI (ir[9]) gives pc_inc if fgi. SKO (ir[8]) gives pc_inc if fgo.
- Undefined: the extra ports are absent, and D=7, I=1 is a NOP that clears SC at T3.

Test Plan:
- Reset, then start with ir=16'h2005 (LDA 005 direct):
  - T0: ar_ld with bus_sel=2.
  - T1: ir_ld with pc_inc and mem_read.
  - T2: ar_ld with bus_sel=5.
  - T3: no strobes.
  - T4: dr_ld with mem_read.
  - T5: ac_ld with alu_op=2.
  - Next cycle: t_state=T0.
- ir=16'h9010 (ADD indirect): T3 has mem_read, bus_sel=7, ar_ld; T5 has ac_ld with alu_op=1. Total 6 cycles.
- ir=16'h6020 (ISZ):
  - dr_zero=1 at T6: pc_inc and mem_write with bus_sel=3.
  - Repeat with dr_zero=0: no pc_inc at T6.
- ir=16'h7004 (SZA): ac_zero=1 gives pc_inc at T3; ac_zero=0 gives none. sc=0 after T3.
- ir=16'h7001 (HLT): run=0 after T3; all strobes 0 for 10 cycles; a start pulse resumes at T0.
- reset_n low during T4 of a BSA: no mem_write after the reset assertion, and all outputs are at reset values at once.
